// File: rtl/uart_rx_pkg.sv
// Shared definitions for the 8N1 UART receiver: FSM encoding (common with uart_tx)
// and frame geometry.
package uart_rx_pkg;

    typedef enum logic [1:0] {
        StStart = 2'b00,
        StData  = 2'b01,
        StStop  = 2'b10,
        StIdle  = 2'b11
    } uart_state_e;

    localparam int unsigned DataBits = 8;

    // Baud counter width; never narrower than one bit for degenerate rates.
    function automatic int unsigned cnt_width(input int unsigned clks);
        return (clks > 2) ? $clog2(clks) : 1;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-in / parallel-out bundle for uart_rx. The slave modport is the receiver side;
// the master modport drives the line and consumes the received bytes.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic                rx;
    logic [DataBits-1:0] data;
    logic                valid;
    logic                frame_err;

    modport master (output rx, input data, input valid, input frame_err);
    modport slave  (input rx, output data, output valid, output frame_err);

endinterface

// File: rtl/uart_rx_sync.sv
// N-flop synchronizer for an asynchronous level input; resets to 1 (idle line).
// N must be at least 2.
module uart_rx_sync #(
    parameter int unsigned N = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_sync;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: falling-edge start detect, mid-bit sampling, one-cycle valid or
// frame_err strobe per frame.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned BAUD = 115200,
    parameter int unsigned F    = 50000000
) (
    input logic       clk,
    input logic       rst,
    uart_rx_if.slave  io_bus
);

    localparam int unsigned CLKS_PER_BIT = F / BAUD;
    localparam int unsigned HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W        = cnt_width(CLKS_PER_BIT);

    localparam logic [CNT_W-1:0] CntHalf = CNT_W'(HALF_BIT - 1);
    localparam logic [CNT_W-1:0] CntFull = CNT_W'(CLKS_PER_BIT - 1);

    logic                w_rx_s;
    logic                r_rx_prev;
    logic                w_fall;
    logic                w_half_tick;
    logic                w_bit_tick;

    uart_state_e         r_state;
    uart_state_e         w_state_next;

    logic [CNT_W-1:0]    r_cnt;
    logic [2:0]          r_bit_idx;
    logic [DataBits-1:0] r_shift;
    logic [DataBits-1:0] r_data;
    logic                r_valid;
    logic                r_frame_err;

    logic                w_cnt_clr;
    logic                w_idx_clr;
    logic                w_shift_en;
    logic                w_valid_d;
    logic                w_frame_err_d;

    uart_rx_sync #(
        .N (2)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .i_d (io_bus.rx),
        .o_q (w_rx_s)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_prev <= w_rx_s;
        end
    end

    // A held-low line (break) never produces an edge, so it cannot re-trigger.
    assign w_fall      = r_rx_prev & ~w_rx_s;
    assign w_half_tick = (r_cnt == CntHalf);
    assign w_bit_tick  = (r_cnt == CntFull);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            StIdle:  if (w_fall) w_state_next = StStart;
            StStart: if (w_half_tick) w_state_next = w_rx_s ? StIdle : StData;
            StData:  if (w_bit_tick && (r_bit_idx == 3'd7)) w_state_next = StStop;
            StStop:  if (w_bit_tick) w_state_next = StIdle;
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_cnt_clr     = 1'b0;
        w_idx_clr     = 1'b0;
        w_shift_en    = 1'b0;
        w_valid_d     = 1'b0;
        w_frame_err_d = 1'b0;
        case (r_state)
            StIdle: begin
                w_cnt_clr = 1'b1;
            end
            StStart: begin
                if (w_half_tick) begin
                    w_cnt_clr = 1'b1;
                    w_idx_clr = 1'b1;
                end
            end
            StData: begin
                if (w_bit_tick) begin
                    w_cnt_clr  = 1'b1;
                    w_shift_en = 1'b1;
                end
            end
            StStop: begin
                if (w_bit_tick) begin
                    w_cnt_clr     = 1'b1;
                    w_valid_d     = w_rx_s;
                    w_frame_err_d = ~w_rx_s;
                end
            end
            default: begin
                w_cnt_clr = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_cnt <= w_cnt_clr ? '0 : r_cnt + CNT_W'(1);
            if (w_idx_clr) begin
                r_bit_idx <= '0;
            end else if (w_shift_en) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end
            // LSB arrives first, so shifting right leaves bit 0 at the bottom after 8 samples.
            if (w_shift_en) begin
                r_shift <= {w_rx_s, r_shift[DataBits-1:1]};
            end
            if (w_valid_d) begin
                r_data <= r_shift;
            end
            r_valid     <= w_valid_d;
            r_frame_err <= w_frame_err_d;
        end
    end

    assign io_bus.data      = r_data;
    assign io_bus.valid     = r_valid;
    assign io_bus.frame_err = r_frame_err;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: a fast-baud instance for framing scenarios and a
// default-rate instance for the glitch and latency checks.
module tb_uart_rx;

    localparam int unsigned F      = 50_000_000;
    localparam int unsigned BAUD_S = 3_125_000;
    localparam int unsigned BAUD_B = 115_200;
    localparam int unsigned CPB_S  = F / BAUD_S;
    localparam int unsigned HALF_S = CPB_S / 2;
    localparam int unsigned CPB_B  = F / BAUD_B;
    localparam int unsigned HALF_B = CPB_B / 2;
    localparam int unsigned LAT_S  = 2 + HALF_S + 9 * CPB_S;
    localparam int unsigned LAT_B  = 2 + HALF_B + 9 * CPB_B;

    logic clk = 1'b0;
    logic rst = 1'b1;

    uart_rx_if bus_s ();
    uart_rx_if bus_b ();

    uart_rx #(.BAUD(BAUD_S), .F(F)) u_dut_s (.clk(clk), .rst(rst), .io_bus(bus_s.slave));
    uart_rx #(.BAUD(BAUD_B), .F(F)) u_dut_b (.clk(clk), .rst(rst), .io_bus(bus_b.slave));

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Events are {is_frame_err, data}; the model holds the last correctly framed byte.
    logic [8:0] ev_s[$];
    logic [8:0] ev_b[$];
    logic [8:0] exp_s[$];
    logic [8:0] exp_b[$];
    logic [7:0] model_s = 8'h00;
    logic [7:0] model_b = 8'h00;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        assert (got === want)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    always @(negedge clk) begin
        if (bus_s.valid === 1'b1 || bus_s.frame_err === 1'b1) begin
            chk("excl_s", {31'b0, bus_s.valid & bus_s.frame_err}, 32'd0);
            ev_s.push_back({bus_s.frame_err, bus_s.data});
        end
        if (bus_b.valid === 1'b1 || bus_b.frame_err === 1'b1) begin
            chk("excl_b", {31'b0, bus_b.valid & bus_b.frame_err}, 32'd0);
            ev_b.push_back({bus_b.frame_err, bus_b.data});
        end
    end

    task automatic drive_line(input bit big, input logic v, input int unsigned n);
        if (big) bus_b.rx = v;
        else     bus_s.rx = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input bit big, input logic [7:0] b, input logic stop_bit,
                              input int unsigned gap);
        int unsigned cpb;
        cpb = big ? CPB_B : CPB_S;
        drive_line(big, 1'b0, cpb);
        for (int i = 0; i < 8; i++) drive_line(big, b[i], cpb);
        drive_line(big, stop_bit, cpb);
        drive_line(big, 1'b1, gap);
    endtask

    // A good stop bit delivers the byte; a bad one reports an error and keeps old data.
    task automatic expect_frame(input bit big, input logic [7:0] b, input logic stop_bit);
        if (big) begin
            if (stop_bit) model_b = b;
            exp_b.push_back({~stop_bit, model_b});
        end else begin
            if (stop_bit) model_s = b;
            exp_s.push_back({~stop_bit, model_s});
        end
    endtask

    task automatic check_events(input bit big, input string tag);
        logic [8:0] got_q[$];
        logic [8:0] want_q[$];
        got_q  = big ? ev_b : ev_s;
        want_q = big ? exp_b : exp_s;
        chk({tag, "_count"}, got_q.size(), want_q.size());
        for (int i = 0; i < want_q.size() && i < got_q.size(); i++) begin
            chk({tag, "_event"}, {23'b0, got_q[i]}, {23'b0, want_q[i]});
        end
        chk({tag, "_data"}, big ? bus_b.data : bus_s.data, big ? model_b : model_s);
        if (big) begin
            ev_b.delete();
            exp_b.delete();
        end else begin
            ev_s.delete();
            exp_s.delete();
        end
    endtask

    task automatic measure(input bit big, input int unsigned limit, output int unsigned lat);
        lat = 0;
        while ((big ? bus_b.valid : bus_s.valid) !== 1'b1 && lat < limit) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    initial begin
        int unsigned lat_s;
        int unsigned lat_b;
        logic [7:0]  b;
        logic        stop_bit;
        int unsigned gap;

        bus_s.rx = 1'b1;
        bus_b.rx = 1'b1;
        rst      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data_s", bus_s.data, 32'h00);
        chk("rst_valid_s", bus_s.valid, 32'h0);
        chk("rst_ferr_s", bus_s.frame_err, 32'h0);
        chk("rst_data_b", bus_b.data, 32'h00);
        chk("rst_valid_b", bus_b.valid, 32'h0);
        chk("rst_ferr_b", bus_b.frame_err, 32'h0);
        rst = 1'b0;
        drive_line(1'b0, 1'b1, 2 * CPB_S);

        // Two frames with idle gaps; the first also times start edge to valid.
        fork
            send_frame(1'b0, 8'hD3, 1'b1, CPB_S);
            measure(1'b0, 2 * LAT_S, lat_s);
        join
        chk("lat_s", {31'b0, (lat_s + 1 >= LAT_S) && (lat_s <= LAT_S + 1)}, 32'd1);
        expect_frame(1'b0, 8'hD3, 1'b1);
        send_frame(1'b0, 8'h2C, 1'b1, CPB_S);
        expect_frame(1'b0, 8'h2C, 1'b1);
        check_events(1'b0, "pair");

        // Back-to-back: the second start bit follows the first stop bit immediately.
        send_frame(1'b0, 8'h00, 1'b1, 0);
        send_frame(1'b0, 8'hFF, 1'b1, CPB_S);
        expect_frame(1'b0, 8'h00, 1'b1);
        expect_frame(1'b0, 8'hFF, 1'b1);
        check_events(1'b0, "b2b");

        drive_line(1'b0, 1'b0, 3);
        drive_line(1'b0, 1'b1, 4 * CPB_S);
        check_events(1'b0, "glitch");

        // Low stop bit, then a break of ten bit times: one error, nothing more.
        send_frame(1'b0, 8'hA5, 1'b0, 0);
        expect_frame(1'b0, 8'hA5, 1'b0);
        drive_line(1'b0, 1'b0, 10 * CPB_S);
        drive_line(1'b0, 1'b1, 2 * CPB_S);
        check_events(1'b0, "ferr");
        send_frame(1'b0, 8'h3C, 1'b1, CPB_S);
        expect_frame(1'b0, 8'h3C, 1'b1);
        check_events(1'b0, "after_break");

        // Reset in the middle of bit 4 aborts the frame without a strobe.
        b = 8'h5A;
        drive_line(1'b0, 1'b0, CPB_S);
        for (int i = 0; i < 4; i++) drive_line(1'b0, b[i], CPB_S);
        drive_line(1'b0, b[4], CPB_S / 2);
        #3 rst = 1'b1;
        #1;
        chk("arst_data", bus_s.data, 32'h00);
        chk("arst_valid", bus_s.valid, 32'h0);
        chk("arst_ferr", bus_s.frame_err, 32'h0);
        model_s  = 8'h00;
        bus_s.rx = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        drive_line(1'b0, 1'b1, 12 * CPB_S);
        check_events(1'b0, "rst_abort");
        send_frame(1'b0, 8'h96, 1'b1, CPB_S);
        expect_frame(1'b0, 8'h96, 1'b1);
        check_events(1'b0, "post_rst");

        // Random bytes, occasional bad stop bits, random inter-frame gaps.
        for (int n = 0; n < 20; n++) begin
            b        = 8'($urandom);
            stop_bit = ($urandom_range(0, 3) != 0);
            gap      = stop_bit ? $urandom_range(0, 20) : CPB_S + $urandom_range(0, 20);
            send_frame(1'b0, b, stop_bit, gap);
            expect_frame(1'b0, b, stop_bit);
        end
        drive_line(1'b0, 1'b1, CPB_S);
        check_events(1'b0, "rand");

        // Default rate: 100-cycle low pulse is ignored and the FSM is idle again in time
        // for a frame starting shortly after HALF_BIT+3.
        drive_line(1'b1, 1'b0, 100);
        drive_line(1'b1, 1'b1, HALF_B + 13 - 100);
        b = 8'($urandom);
        fork
            send_frame(1'b1, b, 1'b1, CPB_B / 4);
            measure(1'b1, 2 * LAT_B, lat_b);
        join
        chk("lat_b", {31'b0, (lat_b + 1 >= LAT_B) && (lat_b <= LAT_B + 1)}, 32'd1);
        expect_frame(1'b1, b, 1'b1);
        check_events(1'b1, "default_rate");
        check_events(1'b0, "quiet_s");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
